// File: rtl/csel_collector_pkg.sv
// Shared types and sizing helpers for the carry-select result collector.
package csel_collector_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    // Chunk counter width; a single-chunk operation still gets one bit.
    function automatic int cnt_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/csel_collector_if.sv
// Chunk-input and result-output bundle between the sum blocks, collector and downstream datapath.
interface csel_collector_if #(
    parameter int WIDTH  = 8,
    parameter int NCHUNK = 4
);
    // Both ports use valid/ready: a transfer happens on a rising edge where valid and ready are
    // both high; a producer holds valid and its payload steady until that edge.
    logic                      c_in;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_s1;
    logic [WIDTH-1:0]          in_s2_n;
    logic                      in_c_out_1;
    logic                      in_c_out_2;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH*NCHUNK-1:0]   out_sum;
    logic                      out_c;
    logic                      err;

    modport master (
        output c_in, in_valid, in_s1, in_s2_n, in_c_out_1, in_c_out_2, out_ready,
        input  in_ready, out_valid, out_sum, out_c, err
    );

    modport slave (
        input  c_in, in_valid, in_s1, in_s2_n, in_c_out_1, in_c_out_2, out_ready,
        output in_ready, out_valid, out_sum, out_c, err
    );
endinterface

// File: rtl/csel_collector_stage.sv
// One chunk of carry selection: picks the candidate matching the carry-in and flags
// candidate pairs whose carry-outs are not monotonic in the carry-in.
module csel_stage #(
    parameter int WIDTH = 8
) (
    input  logic             cin_i,
    input  logic [WIDTH-1:0] s1_i,
    input  logic [WIDTH-1:0] s2_n_i,
    input  logic             c_out_1_i,
    input  logic             c_out_2_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             viol_o
);
    // The carry-in-1 candidate travels inverted, so undo that here.
    assign sum_o  = cin_i ? ~s2_n_i : s1_i;
    assign cout_o = cin_i ? c_out_2_i : c_out_1_i;
    assign viol_o = c_out_1_i & ~c_out_2_i;
endmodule

// File: rtl/csel_collector.sv
// Collects NCHUNK dual-candidate chunks LSB first, resolves the carry chain serially and
// holds the assembled sum and final carry on a valid/ready result port.
module csel_collector
    import csel_collector_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NCHUNK = 4
) (
    input  logic                clk,
    input  logic                rst,
    csel_collector_if.slave     bus,
    output state_e              dbg_state_o
);
    localparam int                CNT_W    = cnt_width(NCHUNK);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NCHUNK - 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     carry_q, carry_d;
    logic [WIDTH*NCHUNK-1:0]  sum_q, sum_d;
    logic                     c_q, c_d;
    logic                     err_q, err_d;

    logic                     accept;
    logic                     last;
    logic                     stage_cin;
    logic [WIDTH-1:0]         stage_sum;
    logic                     stage_cout;
    logic                     stage_viol;

    assign accept    = bus.in_valid && (state_q == COLLECT);
    assign last      = (cnt_q == LAST_CNT);
    assign stage_cin = (cnt_q == '0) ? bus.c_in : carry_q;

    csel_stage #(.WIDTH(WIDTH)) u_stage (
        .cin_i     (stage_cin),
        .s1_i      (bus.in_s1),
        .s2_n_i    (bus.in_s2_n),
        .c_out_1_i (bus.in_c_out_1),
        .c_out_2_i (bus.in_c_out_2),
        .sum_o     (stage_sum),
        .cout_o    (stage_cout),
        .viol_o    (stage_viol)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= COLLECT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (accept && last) state_d = HOLD;
            HOLD:    if (bus.out_ready)  state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == COLLECT);
        bus.out_valid = (state_q == HOLD);
        dbg_state_o   = state_q;
    end

    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        c_d     = c_q;
        err_d   = err_q | (accept & stage_viol);
        if (accept) begin
            carry_d = stage_cout;
            cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
            if (last) c_d = stage_cout;
            for (int k = 0; k < NCHUNK; k++) begin
                if (cnt_q == CNT_W'(k)) sum_d[k*WIDTH +: WIDTH] = stage_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_sum = sum_q;
    assign bus.out_c   = c_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_csel_collector.sv
// Bench for csel_collector: directed cases plus random real-adder operations, checked every
// cycle against an operation-level model (expected results are plain A+B+cin sums).
module tb_csel_collector;
    import csel_collector_pkg::*;

    localparam int W = 8;
    localparam int N = 4;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_e dbg_state;

    csel_collector_if #(.WIDTH(W), .NCHUNK(N)) bus ();

    csel_collector #(.WIDTH(W), .NCHUNK(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Expected {final carry, sum} per operation, oldest first.
    logic [W*N:0] exp_q[$];

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  rand_rdy = 1'b0;
    bit  gaps     = 1'b0;

    // Behavioural model state: result pending downstream, chunks seen, sticky error.
    bit  m_hold = 1'b0;
    int  m_cnt  = 0;
    bit  m_err  = 1'b0;

    task automatic chk(input string name, input logic [W*N:0] act, input logic [W*N:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_chunk(input logic cin, input logic [W-1:0] s1, input logic [W-1:0] s2n,
                               input logic c1, input logic c2);
        bit acc;
        int guard;
        if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_s1    = W'($urandom);
                step();
            end
        end
        bus.in_valid   = 1'b1;
        bus.c_in       = cin;
        bus.in_s1      = s1;
        bus.in_s2_n    = s2n;
        bus.in_c_out_1 = c1;
        bus.in_c_out_2 = c2;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
            guard++;
        end
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: chunk not taken within %0d cycles", guard);
        end
        bus.in_valid = 1'b0;
        bus.c_in     = 1'($urandom);
    endtask

    task automatic send_dir(input logic cin, input logic [W*N-1:0] s1v, input logic [W*N-1:0] s2nv,
                            input logic [N-1:0] c1v, input logic [N-1:0] c2v, input logic [W*N:0] exp);
        exp_q.push_back(exp);
        for (int k = 0; k < N; k++)
            drive_chunk((k == 0) ? cin : 1'($urandom), s1v[k*W +: W], s2nv[k*W +: W], c1v[k], c2v[k]);
    endtask

    // Candidates come from a genuine chunk adder, so the result must be the plain sum.
    task automatic send_real_op(input logic [W*N-1:0] a, input logic [W*N-1:0] b, input logic cin);
        logic [W:0] t1, t2;
        exp_q.push_back({1'b0, a} + {1'b0, b} + {{(W*N){1'b0}}, cin});
        for (int k = 0; k < N; k++) begin
            t1 = {1'b0, a[k*W +: W]} + {1'b0, b[k*W +: W]};
            t2 = t1 + 1'b1;
            drive_chunk((k == 0) ? cin : 1'($urandom), t1[W-1:0], ~t2[W-1:0], t1[W], t2[W]);
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("collect_after_release", {32'd0, bus.in_ready}, 33'd1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            m_hold = 1'b0;
            m_cnt  = 0;
            m_err  = 1'b0;
            exp_q.delete();
        end else begin
            chk("in_ready",  {32'd0, bus.in_ready},  {32'd0, !m_hold});
            chk("out_valid", {32'd0, bus.out_valid}, {32'd0, m_hold});
            chk("err",       {32'd0, bus.err},       {32'd0, m_err});
            if (m_hold) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL result_unexpected: no expected result queued");
                end else begin
                    chk("out_sum", {1'b0, bus.out_sum}, {1'b0, exp_q[0][W*N-1:0]});
                    chk("out_c",   {32'd0, bus.out_c},  {32'd0, exp_q[0][W*N]});
                end
                if (bus.out_ready) begin
                    m_hold = 1'b0;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end else if (bus.in_valid) begin
                if (bus.in_c_out_1 && !bus.in_c_out_2) m_err = 1'b1;
                m_cnt++;
                if (m_cnt == N) begin
                    m_cnt  = 0;
                    m_hold = 1'b1;
                end
            end
        end
    end

    initial begin
        int guard;
        bus.c_in = 1'b0; bus.in_valid = 1'b0; bus.in_s1 = '0; bus.in_s2_n = '0;
        bus.in_c_out_1 = 1'b0; bus.in_c_out_2 = 1'b0; bus.out_ready = 1'b0;

        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        chk("rst_out_valid", {32'd0, bus.out_valid}, 33'd0);
        chk("rst_in_ready",  {32'd0, bus.in_ready},  33'd1);
        chk("rst_out_sum",   {1'b0, bus.out_sum},    33'd0);
        chk("rst_out_c",     {32'd0, bus.out_c},     33'd0);
        chk("rst_err",       {32'd0, bus.err},       33'd0);

        // 0x000000FF + 0x01: carry out of chunk 0 into chunk 1.
        send_dir(1'b0, 32'h0000_0000, 32'hFEFE_FEFE, 4'b0001, 4'b0001, 33'h0_0000_0100);
        chk("c1_sum", {1'b0, bus.out_sum}, 33'h0_0000_0100);
        chk("c1_c",   {32'd0, bus.out_c},  33'd0);
        release_result();

        // 0xFFFFFFFF + 0 + 1: carry ripples through every chunk.
        send_dir(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000, 4'b1111, 33'h1_0000_0000);
        chk("ripple_latency", {32'd0, bus.out_valid}, 33'd1);
        chk("ripple_sum", {1'b0, bus.out_sum}, 33'h0_0000_0000);
        chk("ripple_c",   {32'd0, bus.out_c},  33'd1);

        // Backpressure: offered chunks must be ignored while the result waits.
        bus.in_valid = 1'b1;
        repeat (5) begin
            bus.in_s1 = W'($urandom); bus.in_s2_n = W'($urandom);
            bus.in_c_out_1 = 1'b0;    bus.in_c_out_2 = 1'($urandom);
            step();
            chk("bp_out_valid", {32'd0, bus.out_valid}, 33'd1);
            chk("bp_in_ready",  {32'd0, bus.in_ready},  33'd0);
            chk("bp_sum",       {1'b0, bus.out_sum},    33'h0_0000_0000);
        end
        bus.in_valid = 1'b0;
        release_result();

        // Reset in the middle of an operation discards the partial result.
        drive_chunk(1'b0, 8'h00, 8'hFE, 1'b1, 1'b1);
        drive_chunk(1'b0, 8'h00, 8'hFE, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_in_ready", {32'd0, bus.in_ready}, 33'd1);
        chk("midrst_sum",      {1'b0, bus.out_sum},   33'd0);
        send_dir(1'b0, 32'h0000_0000, 32'hFEFE_FEFE, 4'b0001, 4'b0001, 33'h0_0000_0100);
        chk("midrst_result", {1'b0, bus.out_sum}, 33'h0_0000_0100);
        release_result();

        // Non-monotonic carries on chunk 0 raise err; data still resolves (carry 1 into chunk 1).
        exp_q.push_back(33'h0_0000_0112);
        drive_chunk(1'b0, 8'h12, ~8'h13, 1'b1, 1'b0);
        chk("err_set", {32'd0, bus.err}, 33'd1);
        for (int k = 1; k < N; k++) drive_chunk(1'($urandom), 8'h00, 8'hFE, 1'b0, 1'b0);
        chk("err_sum",  {1'b0, bus.out_sum}, 33'h0_0000_0112);
        chk("err_held", {32'd0, bus.err},    33'd1);
        release_result();
        chk("err_sticky", {32'd0, bus.err}, 33'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("err_cleared", {32'd0, bus.err}, 33'd0);

        // Random real-adder operations with input gaps and random downstream stalls.
        rand_rdy = 1'b1;
        gaps     = 1'b1;
        repeat (40) send_real_op(32'($urandom), 32'($urandom), 1'($urandom));
        guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            step();
            guard++;
        end
        chk("drain", {1'b0, 32'(exp_q.size())}, 33'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
